// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter merging NREQ requesters into one shared FIFO write port
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int BURST_MAX = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DW-1:0]     fifo_data,
  output logic              grant_valid,
  output logic [IW-1:0]     grant_id
);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, winner, idx;
  logic [3:0] beat_q, beat_d;
  logic grant, accept;
  assign grant = state_q == GRANT;
  assign accept = grant && req_valid[owner_q] && !fifo_full;
  // winner search: descending scan so the nearest valid requester above last owner wins
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      winner = req_valid[idx] ? idx : winner;
    end
  end
  // next state: arbitrate in IDLE, count beats and release the grant in GRANT
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d = beat_q;
    last_d = last_q;
    if (!grant) begin
      state_d = |req_valid ? GRANT : IDLE;
      owner_d = |req_valid ? winner : owner_q;
      beat_d = |req_valid ? '0 : beat_q;
    end else if (!req_valid[owner_q] || (accept && beat_q == 4'(BURST_MAX - 1))) begin
      state_d = IDLE;
      last_d = owner_q;
    end else begin
      beat_d = accept ? beat_q + 4'd1 : beat_q;
    end
  end
  // outputs, all forced low while reset is held
  always_comb begin
    fifo_wr = accept && !rst;
    grant_valid = grant && !rst;
    req_ready = fifo_wr ? NREQ'(1) << owner_q : '0;
    grant_id = grant_valid ? owner_q : '0;
    fifo_data = '0;
    for (int i = 0; i < NREQ; i++)
      fifo_data = (grant_valid && owner_q == IW'(i)) ? req_data[i*DW +: DW] : fifo_data;
  end
  // state register; reset gives requester 0 first priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q <= '0;
      last_q <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q <= beat_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized scoreboard run for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 8, BURST_MAX = 4, IW = $clog2(NREQ);
  logic clk = 0, rst = 1, fifo_full = 0, fifo_wr, grant_valid;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [DW-1:0] fifo_data;
  logic [IW-1:0] grant_id;
  logic [DW-1:0] base [NREQ];
  int seq [NREQ];
  int n_chk = 0, n_fail = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // each requester presents base+seq and advances seq only when its beat is accepted
  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = base[i] + DW'(seq[i]);
  endtask

  task automatic next_cycle();
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) seq[i]++;
    @(negedge clk);
    drive_data();
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; fifo_full = 0;
    next_cycle(); next_cycle();
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    drive_data();
    rst = 0;
  endtask

  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1; req_valid = '1; fifo_full = 0;
    for (int i = 0; i < NREQ; i++) begin base[i] = DW'(16 * i + 1); seq[i] = 0; end
    drive_data();
    next_cycle(); next_cycle();
    #1;
    n_chk++;
    if (fifo_wr !== 1'b0 || grant_valid !== 1'b0 || req_ready !== '0 || grant_id !== '0 || fifo_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr=%b gv=%b ready=%b id=%0d data=%h, want all zero", fifo_wr, grant_valid, req_ready, grant_id, fifo_data);
    end
    next_cycle();
    rst = 0;
    #1;
    n_chk++;
    if (grant_valid !== 1'b0 || fifo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_idle: gv=%b wr=%b, want 0 0", grant_valid, fifo_wr);
    end
    next_cycle();
    #1;
    n_chk++;
    if (grant_valid !== 1'b1 || grant_id !== '0 || fifo_wr !== 1'b1 || fifo_data !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_first_grant: gv=%b id=%0d wr=%b data=%h, want 1 0 1 01", grant_valid, grant_id, fifo_wr, fifo_data);
    end
    next_cycle();
  endtask

  task automatic test_single();
    bit e_gv [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    bit e_wr [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    logic [7:0] e_d [10] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h15, 8'h16, 8'h17, 8'h00};
    do_reset();
    base[0] = 8'h11; drive_data();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b0001 : 4'b0000;
      #1;
      n_chk++;
      if (grant_valid !== e_gv[c] || fifo_wr !== e_wr[c] || fifo_data !== e_d[c] || req_ready !== {3'b000, e_wr[c]} || grant_id !== '0) begin
        n_fail++;
        $display("FAIL single c%0d: gv=%b wr=%b data=%h ready=%b id=%0d, want gv=%b wr=%b data=%h id=0", c, grant_valid, fifo_wr, fifo_data, req_ready, grant_id, e_gv[c], e_wr[c], e_d[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) base[i] = DW'(16 * i);
    drive_data();
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      #1;
      n_chk++;
      if (grant_valid !== 1'b0 || fifo_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle g%0d: gv=%b wr=%b, want 0 0", g, grant_valid, fifo_wr);
      end
      next_cycle();
      for (int b = 0; b < 4; b++) begin
        #1;
        n_chk++;
        if (grant_valid !== 1'b1 || grant_id !== IW'(g % 4) || fifo_wr !== 1'b1 || req_ready !== (4'b0001 << (g % 4)) || fifo_data !== DW'((g % 4) * 16 + (g / 4) * 4 + b)) begin
          n_fail++;
          $display("FAIL rr_beat g%0d b%0d: gv=%b id=%0d wr=%b ready=%b data=%h, want 1 %0d 1 data=%h", g, b, grant_valid, grant_id, fifo_wr, req_ready, fifo_data, g % 4, DW'((g % 4) * 16 + (g / 4) * 4 + b));
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_stall();
    bit e_full [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    bit e_wr [9]   = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    bit e_gv [9]   = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int k = 0, nw = 0;
    do_reset();
    base[2] = 8'h20; drive_data();
    req_valid = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      fifo_full = e_full[c];
      #1;
      n_chk++;
      if (grant_valid !== e_gv[c] || fifo_wr !== e_wr[c] || req_ready !== (e_wr[c] ? 4'b0100 : 4'b0000) || (e_gv[c] && (grant_id !== IW'(2) || fifo_data !== 8'h20 + 8'(k)))) begin
        n_fail++;
        $display("FAIL stall c%0d: gv=%b wr=%b ready=%b id=%0d data=%h, want gv=%b wr=%b id=2 data=%h", c, grant_valid, fifo_wr, req_ready, grant_id, fifo_data, e_gv[c], e_wr[c], 8'h20 + 8'(k));
      end
      k += int'(e_wr[c]);
      nw += int'(fifo_wr);
      next_cycle();
    end
    fifo_full = 0;
    n_chk++;
    if (nw !== 4) begin
      n_fail++;
      $display("FAIL stall_beats: wrote %0d, want 4", nw);
    end
  endtask

  task automatic test_release();
    logic [3:0] e_v [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
    bit e_gv [6] = '{0, 1, 1, 1, 0, 1};
    bit e_wr [6] = '{0, 1, 1, 0, 0, 1};
    logic [3:0] e_r [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1000};
    logic [IW-1:0] e_id [6] = '{0, 1, 1, 1, 0, 3};
    logic [7:0] e_d [6] = '{8'h00, 8'h30, 8'h31, 8'h32, 8'h00, 8'h50};
    do_reset();
    base[1] = 8'h30; base[3] = 8'h50; drive_data();
    for (int c = 0; c < 6; c++) begin
      req_valid = e_v[c];
      #1;
      n_chk++;
      if (grant_valid !== e_gv[c] || fifo_wr !== e_wr[c] || req_ready !== e_r[c] || fifo_data !== e_d[c] || (e_gv[c] && grant_id !== e_id[c])) begin
        n_fail++;
        $display("FAIL release c%0d: gv=%b wr=%b ready=%b id=%0d data=%h, want gv=%b wr=%b ready=%b id=%0d data=%h", c, grant_valid, fifo_wr, req_ready, grant_id, fifo_data, e_gv[c], e_wr[c], e_r[c], e_id[c], e_d[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    base[0] = 8'h40; base[1] = 8'h60; drive_data();
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (grant_valid !== (c > 0) || fifo_wr !== (c > 0) || (c > 0 && (grant_id !== IW'(1) || fifo_data !== 8'h60 + 8'(c - 1)))) begin
        n_fail++;
        $display("FAIL rstmid_pre c%0d: gv=%b wr=%b id=%0d data=%h", c, grant_valid, fifo_wr, grant_id, fifo_data);
      end
      next_cycle();
    end
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if (fifo_wr !== 1'b0 || grant_valid !== 1'b0 || req_ready !== '0 || grant_id !== '0 || fifo_data !== '0) begin
        n_fail++;
        $display("FAIL rstmid_zero c%0d: wr=%b gv=%b ready=%b id=%0d data=%h, want all zero", c, fifo_wr, grant_valid, req_ready, grant_id, fifo_data);
      end
      next_cycle();
    end
    rst = 0; req_valid = 4'b0011;
    #1;
    n_chk++;
    if (grant_valid !== 1'b0 || fifo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: gv=%b wr=%b, want 0 0", grant_valid, fifo_wr);
    end
    next_cycle();
    #1;
    n_chk++;
    if (grant_valid !== 1'b1 || grant_id !== '0 || fifo_wr !== 1'b1 || fifo_data !== 8'h40) begin
      n_fail++;
      $display("FAIL rstmid_regrant: gv=%b id=%0d wr=%b data=%h, want 1 0 1 40", grant_valid, grant_id, fifo_wr, fifo_data);
    end
    next_cycle();
  endtask

  task automatic test_random();
    bit m_gv = 0;
    int m_own = 0, m_last = NREQ - 1, beats = 0;
    int wt [NREQ];
    logic [NREQ-1:0] p_v = '0, e_rdy;
    bit e_wr, starve;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin base[i] = DW'(64 * i); wt[i] = 0; end
    drive_data();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 5) == 0) req_valid[i] = ~req_valid[i];
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      if (!m_gv) begin
        if (|p_v) begin
          m_own = rr_pick(m_last, p_v);
          m_gv = 1;
          beats = 0;
          starve = 0;
          for (int i = 0; i < NREQ; i++) begin
            wt[i] = (i == m_own || !p_v[i]) ? 0 : wt[i] + 1;
            if (wt[i] > NREQ) starve = 1;
          end
          n_chk++;
          if (starve) begin
            n_fail++;
            $display("FAIL rand_starve cycle %0d: a waiting requester passed over more than %0d grants", c, NREQ);
          end
        end
      end else if (beats == BURST_MAX || !p_v[m_own]) begin
        m_gv = 0;
        m_last = m_own;
      end
      n_chk++;
      if (grant_valid !== m_gv || (m_gv && grant_id !== IW'(m_own))) begin
        n_fail++;
        $display("FAIL rand_grant cycle %0d: gv=%b id=%0d, want gv=%b id=%0d", c, grant_valid, grant_id, m_gv, m_own);
      end
      e_wr = m_gv && req_valid[m_own] && !fifo_full;
      e_rdy = e_wr ? (NREQ'(1) << m_own) : '0;
      n_chk++;
      if (fifo_wr !== e_wr || req_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL rand_wr cycle %0d: wr=%b ready=%b, want wr=%b ready=%b", c, fifo_wr, req_ready, e_wr, e_rdy);
      end
      if (e_wr) begin
        n_chk++;
        if (fifo_data !== base[m_own] + DW'(seq[m_own])) begin
          n_fail++;
          $display("FAIL rand_data cycle %0d: data=%h, want %h from requester %0d", c, fifo_data, base[m_own] + DW'(seq[m_own]), m_own);
        end
        beats++;
      end
      n_chk++;
      if (fifo_wr === 1'b1 && fifo_full === 1'b1) begin
        n_fail++;
        $display("FAIL rand_full cycle %0d: wr=1 while full=1, want wr=0", c);
      end
      p_v = req_valid;
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin base[i] = '0; seq[i] = 0; end
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_release();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 8, data width; matches the shared 16-deep FIFO.
REQ-003 Parameter BURST_MAX, default 4, maximum beats per grant (1..15).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester beat available.
REQ-007 req_data  input  NREQ*DW  packed requester data; requester i occupies bits [i*DW +: DW].
REQ-008 req_ready  output  NREQ  per-requester beat accepted this cycle.
REQ-009 fifo_full  input  1  full flag from the shared FIFO.
REQ-010 fifo_wr  output  1  write strobe to the shared FIFO.
REQ-011 fifo_data  output  DW  write data to the shared FIFO.
REQ-012 grant_valid  output  1  high while in GRANT.
REQ-013 grant_id  output  clog2(NREQ)  current owner index; valid only when grant_valid=1.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-015 In IDLE with any req_valid high, the block SHALL select the winner round-robin, searching from last_owner+1 upward modulo NREQ.
REQ-016 On that IDLE cycle, it SHALL register owner=winner, clear beat_cnt, and enter GRANT on the next edge; arbitration latency is 1 cycle with no transfer.
REQ-017 In IDLE with no req_valid high, it SHALL remain in IDLE.
REQ-018 A beat is accepted when: state=GRANT, req_valid[owner]=1 and fifo_full=0.
REQ-019 On an accepted beat, fifo_wr and req_ready[owner] SHALL be 1 combinationally in the same cycle.
REQ-020 fifo_wr SHALL be 0 in every other cycle, and every other req_ready bit SHALL be 0 in every cycle.
REQ-021 fifo_data SHALL equal req_data[owner] while in GRANT, and 0 in IDLE.
REQ-022 beat_cnt SHALL increment by 1 on each accepted beat.
REQ-023 When a beat is accepted with beat_cnt=BURST_MAX-1, the block SHALL go to IDLE next cycle and set last_owner=owner.
REQ-024 In GRANT with req_valid[owner]=0, the block SHALL go to IDLE next cycle and set last_owner=owner, with no transfer that cycle.
REQ-025 In GRANT with fifo_full=1 and req_valid[owner]=1, it SHALL stall: state, owner and beat_cnt held, no write, grant not released.
REQ-026 Valid changes by non-owners SHALL NOT affect the current grant.
REQ-027 A requester SHALL NOT receive two consecutive grants while another requester had req_valid high during the intervening IDLE cycle (round-robin fairness).
REQ-028 The block SHALL never assert fifo_wr while fifo_full=1.
REQ-029 Every beat SHALL be written to the FIFO once and only once; beats SHALL never be duplicated or dropped.

Reset
REQ-030 While rst=1, the FSM SHALL be forced to IDLE, including mid-burst, and the partial burst is abandoned.
REQ-031 Reset values SHALL be: owner=0, beat_cnt=0, last_owner=NREQ-1 (requester 0 has first priority).
REQ-032 While rst=1, fifo_wr, req_ready, grant_valid, grant_id and fifo_data SHALL be 0.
REQ-033 The first arbitration SHALL occur in the first cycle after rst deasserts.

Verification
REQ-034 Reset, then req_valid=4'b0001 held, fifo_full=0, data 0x11..0x16 -> IDLE 1 cycle, 4 writes 0x11..0x14, IDLE 1 cycle, regrant to 0, writes 0x15, 0x16.
REQ-035 All four requesters valid continuously -> grant order 0,1,2,3,0; each grant exactly 4 beats; each grant separated by 1 idle cycle.
REQ-036 Requester 2 granted, fifo_full=1 for 3 cycles mid-burst -> fifo_wr=0 and req_ready=0 for those cycles; burst resumes with beat_cnt preserved; total 4 beats.
REQ-037 Owner 1 drops req_valid after 2 beats while 3 is valid -> release after 2 beats; next grant goes to 3.
REQ-038 rst asserted mid-burst after beat 2 -> outputs 0 next edge; after release, requester 0 wins if valid.
REQ-039 Random valid/full stimulus over 10k cycles -> scoreboard checks per-requester in-order data with no loss or duplication, fifo_wr never high while full, and no requester starved for more than NREQ grants.
